// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S receive path:
//   - DATA_W_DEF : default captured bits per channel slot
//   - PCM_MAX_W  : widest sample accepted by to_pcm8 (samples are MSB-aligned
//                  into this width by the caller)
//   - state_t    : receiver slot state machine encoding
//   - to_pcm8    : 8-bit recovery of a wide sample, truncating toward zero,
//                  shared with the transmit side for loopback comparison
// -----------------------------------------------------------------------------
package i2s_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int PCM_MAX_W  = 32;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // s_al is the sample MSB-aligned in PCM_MAX_W bits; zero padding below the
    // real LSB leaves the "any discarded bit set" test unchanged.
    function automatic logic [7:0] to_pcm8(input logic [PCM_MAX_W-1:0] s_al);
        logic [7:0] t;
        t = s_al[PCM_MAX_W-1 -: 8];
        if (s_al[PCM_MAX_W-1] && (s_al[PCM_MAX_W-9:0] != '0)) begin
            return t + 8'd1;
        end
        return t;
    endfunction

endpackage

// File: rtl/i2s_sync.sv
// -----------------------------------------------------------------------------
// i2s_sync
// Two-flop synchroniser for one asynchronous pin, plus single-cycle edge pulses
// derived from the synchronised value.
// Ports:
//   i_clk   system clock
//   i_rst   synchronous active-high reset
//   i_d     asynchronous input pin
//   o_q     synchronised level
//   o_rise  one-cycle pulse on a synchronised 0->1 transition
//   o_edge  one-cycle pulse on any synchronised transition
// Every pin uses the same depth, so pins sampled together stay in order.
// -----------------------------------------------------------------------------
module i2s_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_q    = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_edge = r_sync ^ r_prev;

endmodule

// File: rtl/i2s_rx.sv
// -----------------------------------------------------------------------------
// i2s_rx
// I2S receiver: deserialises SCLK/LRCLK/DIN from a codec into left/right PCM
// frames in the Clk domain, delivered over a valid/ready handshake, together
// with 8-bit recovered samples.
// Ports:
//   Clk, Reset        system clock, synchronous active-high reset
//   SCLK, LRCLK, DIN  codec pins (asynchronous; LRCLK 0 = left, 1 = right)
//   out_ready         consumer accepts the held frame
//   out_valid         a frame is held in left/right/left8/right8
//   left, right       DATA_W-bit two's complement samples
//   left8, right8     8-bit recovered samples
//   overrun           sticky: a completed frame was dropped
//   short_slot        sticky: a slot ended before DATA_W bits arrived
// Clk must run at least 4x SCLK. DATA_W must lie in 8..PCM_MAX_W.
// -----------------------------------------------------------------------------
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int I2S_DELAY = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              SCLK,
    input  logic              LRCLK,
    input  logic              DIN,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] left,
    output logic [DATA_W-1:0] right,
    output logic [7:0]        left8,
    output logic [7:0]        right8,
    output logic              overrun,
    output logic              short_slot
);

    localparam int              CW        = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};
    localparam bit              LJ        = (I2S_DELAY == 0);
    // The rise that reveals the LRCLK change is itself the first skipped rise,
    // so only the remaining I2S_DELAY-1 rises are spent in DELAY.
    localparam logic [7:0]      SKIP_INIT = (I2S_DELAY > 1) ? 8'(I2S_DELAY - 1) : 8'd0;
    localparam state_t          START_ST  = (I2S_DELAY > 1) ? DELAY : SHIFT;

    logic w_sclk_q, w_sclk_rise, w_sclk_edge;
    logic w_lr, w_lr_rise, w_lr_edge;
    logic w_din, w_din_rise, w_din_edge;
    logic w_unused;

    i2s_sync u_sync_sclk (.i_clk(Clk), .i_rst(Reset), .i_d(SCLK),
                          .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_edge(w_sclk_edge));
    i2s_sync u_sync_lr   (.i_clk(Clk), .i_rst(Reset), .i_d(LRCLK),
                          .o_q(w_lr), .o_rise(w_lr_rise), .o_edge(w_lr_edge));
    i2s_sync u_sync_din  (.i_clk(Clk), .i_rst(Reset), .i_d(DIN),
                          .o_q(w_din), .o_rise(w_din_rise), .o_edge(w_din_edge));

    assign w_unused = w_sclk_q ^ w_sclk_edge ^ w_lr_rise ^ w_lr_edge ^ w_din_rise ^ w_din_edge;

    state_t              r_state, w_state_nxt;
    logic                r_lr_last;
    logic [DATA_W-1:0]   r_slot;
    logic [CW-1:0]       r_bitcnt;
    logic [7:0]          r_skip;
    logic                r_chan;
    logic [DATA_W-1:0]   r_pend;

    logic                w_lre;
    logic                w_start, w_cap, w_full, w_close;
    logic [DATA_W-1:0]   w_slot_cap;
    logic [CW-1:0]       w_cnt_cap;
    logic [DATA_W-1:0]   w_closed;
    logic                w_commit, w_can_load;
    logic [PCM_MAX_W-1:0] w_left_al, w_right_al;

    // LRCLK is compared against its value at the previous SCLK rise, so a
    // word-select change is seen exactly on the first rise after it.
    assign w_lre = w_sclk_rise & (w_lr != r_lr_last);

    // Slot register is filled MSB-first at its final position; unfilled LSBs
    // stay zero, which gives the left-aligned zero padding for short slots.
    assign w_slot_cap = r_slot | (w_din ? (MSB_ONE >> r_bitcnt) : '0);
    assign w_cnt_cap  = r_bitcnt + CW'(1);
    assign w_closed   = w_cap ? w_slot_cap : r_slot;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_cap       = 1'b0;
        w_full      = 1'b0;
        w_close     = 1'b0;
        if (w_sclk_rise) begin
            case (r_state)
                SYNC: begin
                    // only a 1->0 change qualifies, so capture always opens on left
                    if (w_lre && !w_lr) begin
                        w_start     = 1'b1;
                        w_state_nxt = START_ST;
                    end
                end
                DELAY: begin
                    if (r_skip <= 8'd1) w_state_nxt = SHIFT;
                end
                SHIFT: begin
                    // With a delay, the bit on the LRCLK-change rise still belongs
                    // to the slot being closed; left-justified, it opens the next.
                    w_cap   = !(w_lre && LJ);
                    w_full  = w_cap && (w_cnt_cap == CW'(DATA_W));
                    w_close = w_full || w_lre;
                    if (w_lre) begin
                        w_start     = 1'b1;
                        w_state_nxt = START_ST;
                    end else if (w_full) begin
                        w_state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (w_lre) begin
                        w_start     = 1'b1;
                        w_state_nxt = START_ST;
                    end
                end
                default: w_state_nxt = SYNC;
            endcase
        end
    end

    assign w_commit   = w_close & r_chan;
    assign w_can_load = ~out_valid | out_ready;
    assign w_left_al  = PCM_MAX_W'(r_pend) << (PCM_MAX_W - DATA_W);
    assign w_right_al = PCM_MAX_W'(w_closed) << (PCM_MAX_W - DATA_W);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= SYNC;
            r_lr_last  <= 1'b0;
            r_slot     <= '0;
            r_bitcnt   <= '0;
            r_skip     <= '0;
            r_chan     <= 1'b0;
            r_pend     <= '0;
            out_valid  <= 1'b0;
            left       <= '0;
            right      <= '0;
            left8      <= '0;
            right8     <= '0;
            overrun    <= 1'b0;
            short_slot <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_sclk_rise) r_lr_last <= w_lr;

            if (w_start) begin
                r_chan <= w_lr;
                r_skip <= SKIP_INIT;
                if (LJ) begin
                    r_slot   <= w_din ? MSB_ONE : '0;
                    r_bitcnt <= CW'(1);
                end else begin
                    r_slot   <= '0;
                    r_bitcnt <= '0;
                end
            end else if (w_cap) begin
                r_slot   <= w_slot_cap;
                r_bitcnt <= w_cnt_cap;
            end else if (w_sclk_rise && r_state == DELAY) begin
                r_skip <= r_skip - 8'd1;
            end

            if (w_close && !r_chan) r_pend <= w_closed;
            if (w_close && !w_full) short_slot <= 1'b1;

            if (w_commit && w_can_load) begin
                out_valid <= 1'b1;
                left      <= r_pend;
                right     <= w_closed;
                left8     <= to_pcm8(w_left_al);
                right8    <= to_pcm8(w_right_al);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_commit && !w_can_load) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
module tb_i2s_rx;

    localparam int DW = 24;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          SCLK = 1'b0;
    logic          LRCLK = 1'b1;
    logic          DIN = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] left, right;
    logic [7:0]    left8, right8;
    logic          overrun, short_slot;

    always #5 Clk = ~Clk;

    i2s_rx #(.DATA_W(DW), .I2S_DELAY(1)) dut (
        .Clk(Clk), .Reset(Reset), .SCLK(SCLK), .LRCLK(LRCLK), .DIN(DIN),
        .out_ready(out_ready), .out_valid(out_valid), .left(left), .right(right),
        .left8(left8), .right8(right8), .overrun(overrun), .short_slot(short_slot)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
        logic [7:0]  l8;
        logic [7:0]  r8;
    } frame_t;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [7:0]  l8;
        logic [7:0]  r8;
    } vec_t;

    frame_t exp_q[$];
    frame_t mon_f;
    vec_t   vecs[8];
    logic   tail = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // reference: signed sample divided by 2^(DW-8), C-style truncation toward zero
    function automatic logic [7:0] pcm8_model(input logic [23:0] s);
        int v;
        v = int'($signed(s));
        return 8'(v / 65536);
    endfunction

    task automatic push_model(input logic [23:0] l, input logic [23:0] r);
        frame_t f;
        f.l = l; f.r = r; f.l8 = pcm8_model(l); f.r8 = pcm8_model(r);
        exp_q.push_back(f);
    endtask

    // scoreboard: every accepted frame is compared with the oldest expectation
    always @(negedge Clk) begin
        if (!Reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_frame actual left=%h right=%h expected none", left, right);
            end else begin
                mon_f = exp_q.pop_front();
                chk("left", 32'(left), 32'(mon_f.l));
                chk("right", 32'(right), 32'(mon_f.r));
                chk("left8", 32'(left8), 32'(mon_f.l8));
                chk("right8", 32'(right8), 32'(mon_f.r8));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // LRCLK/DIN change while SCLK is low; the codec bit is valid at SCLK rise
    task automatic send_bit(input logic lr, input logic d);
        SCLK = 1'b0; LRCLK = lr; DIN = d;
        tick(4);
        SCLK = 1'b1;
        tick(4);
    endtask

    function automatic logic slot_bit(input logic [31:0] val, input int nvalid, input int j);
        if (j < nvalid) return val[nvalid-1-j];
        return 1'($urandom_range(0, 1));
    endfunction

    // Standard I2S: the first rise after an LRCLK change carries the previous
    // slot's last bit (tail); this slot's own last bit goes out as the next tail.
    task automatic send_slot(input logic lr, input logic [31:0] val, input int nvalid,
                             input int nsend);
        for (int i = 0; i < nsend; i++) begin
            send_bit(lr, (i == 0) ? tail : slot_bit(val, nvalid, i - 1));
        end
        tail = slot_bit(val, nvalid, nsend - 1);
    endtask

    task automatic flush();
        send_bit(1'b0, tail);
        tick(6);
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        tick(n);
        Reset = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_left"}, 32'(left), 32'd0);
        chk({tag, "_right"}, 32'(right), 32'd0);
        chk({tag, "_left8"}, 32'(left8), 32'd0);
        chk({tag, "_right8"}, 32'(right8), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_short_slot"}, 32'(short_slot), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{24'h7F7F7F, 24'h808081, 8'h7F, 8'h81};
        vecs[1] = '{24'h7F7F7F, 24'h808081, 8'h7F, 8'h81};
        vecs[2] = '{24'h7F7F7F, 24'h808081, 8'h7F, 8'h81};
        vecs[3] = '{24'h800000, 24'hFEFEFF, 8'h80, 8'hFF};
        vecs[4] = '{24'h800000, 24'h010000, 8'h80, 8'h01};
        vecs[5] = '{24'hFF0000, 24'h000000, 8'hFF, 8'h00};
        vecs[6] = '{24'h123456, 24'hFFFFFF, 8'h12, 8'h00};
        vecs[7] = '{24'h7FFFFF, 24'h80FFFF, 8'h7F, 8'h81};

        // reset state
        do_reset(4);
        chk_zero("reset");

        // table frames, stream joins in the middle of a right slot
        out_ready = 1'b1;
        send_slot(1'b1, $urandom, 24, 10);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({vecs[i].l, vecs[i].r, vecs[i].l8, vecs[i].r8});
            send_slot(1'b0, 32'(vecs[i].l), 24, 24);
            send_slot(1'b1, 32'(vecs[i].r), 24, 24);
        end
        flush();
        chk("table_drained", 32'(exp_q.size()), 32'd0);
        chk("table_overrun", 32'(overrun), 32'd0);
        chk("table_short", 32'(short_slot), 32'd0);

        // long slots with junk, then short slots
        do_reset(1);
        send_slot(1'b1, $urandom, 24, 24);
        push_model(24'h123456, 24'h654321);
        send_slot(1'b0, 32'h123456, 24, 32);
        send_slot(1'b1, 32'h654321, 24, 32);
        push_model(24'hABCD00, 24'h123400);
        send_slot(1'b0, 32'hABCD, 16, 16);
        chk("long_short_flag", 32'(short_slot), 32'd0);
        send_slot(1'b1, 32'h1234, 16, 16);
        flush();
        chk("short_flag", 32'(short_slot), 32'd1);
        chk("short_drained", 32'(exp_q.size()), 32'd0);

        // back-pressure: F2 dropped while F1 held
        do_reset(1);
        out_ready = 1'b0;
        send_slot(1'b1, $urandom, 24, 24);
        push_model(24'h000001, 24'h000002);
        send_slot(1'b0, 32'h1, 24, 24);
        send_slot(1'b1, 32'h2, 24, 24);
        send_slot(1'b0, 32'h3, 24, 24);
        send_slot(1'b1, 32'h4, 24, 24);
        send_slot(1'b0, 32'h5, 24, 24);
        tick(6);
        chk("ovr_valid", 32'(out_valid), 32'd1);
        chk("ovr_left_held", 32'(left), 32'h1);
        chk("ovr_right_held", 32'(right), 32'h2);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_short", 32'(short_slot), 32'd0);
        out_ready = 1'b1;
        @(negedge Clk);
        tick(1);
        @(negedge Clk);
        chk("ovr_valid_cleared", 32'(out_valid), 32'd0);
        push_model(24'h000005, 24'h000006);
        send_slot(1'b1, 32'h6, 24, 24);
        flush();
        chk("ovr_drained", 32'(exp_q.size()), 32'd0);

        // reset asserted 10 bits into a left slot
        do_reset(1);
        send_slot(1'b1, $urandom, 24, 24);
        push_model(24'h5A5A5A, 24'hA5A5A5);
        send_slot(1'b0, 32'h5A5A5A, 24, 24);
        send_slot(1'b1, 32'hA5A5A5, 24, 24);
        send_slot(1'b0, 32'h3C3C3C, 24, 10);
        chk("pre_reset_left", 32'(left), 32'h5A5A5A);
        do_reset(1);
        #1;
        chk_zero("midreset");
        send_slot(1'b0, 32'h3C3C3C, 24, 4);
        send_slot(1'b1, $urandom, 24, 24);
        push_model(24'h0F1E2D, 24'hC3B4A5);
        send_slot(1'b0, 32'h0F1E2D, 24, 24);
        send_slot(1'b1, 32'hC3B4A5, 24, 24);
        flush();
        chk("post_reset_drained", 32'(exp_q.size()), 32'd0);
        chk("post_reset_overrun", 32'(overrun), 32'd0);
        chk("post_reset_short", 32'(short_slot), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver: deserialises an external codec/ADC bit stream (SCLK, LRCLK, DIN) into parallel left/right PCM frames in the system clock domain.
- Inverse of the audio output path. It also recovers 8-bit samples matching the on-chip 8-bit sample format, so captured audio can be looped back or compared against generated audio.
- Sits between the codec pins and the audio/sample consumer; frames are delivered over a valid/ready handshake.

Parameters:
- DATA_W, 24: bits per channel slot captured, MSB first; must be ≥ 8.
- I2S_DELAY, 1: SCLK rising edges skipped after each LRCLK transition (1 = standard I2S, 0 = left-justified).

Ports:
- Clk  in  1  system clock; frequency ≥ 4× SCLK.
- Reset  in  1  synchronous, active-high reset.
- SCLK  in  1  codec bit clock, asynchronous to Clk.
- LRCLK  in  1  codec word select, asynchronous; 0 = left slot, 1 = right slot.
- DIN  in  1  serial data, valid at SCLK rising edge.
- out_ready  in  1  consumer accepts the frame.
- out_valid  out  1  frame held in output register.
- left  out  DATA_W  left sample, two's complement.
- right  out  DATA_W  right sample, two's complement.
- left8  out  8  8-bit recovered left sample.
- right8  out  8  8-bit recovered right sample.
- overrun  out  1  sticky: a completed frame was dropped.
- short_slot  out  1  sticky: a slot ended before DATA_W bits arrived.

Behaviour:
- Clock/reset:
  - One clock (Clk); reset is synchronous and active-high (Reset).
  - On Reset: all outputs 0; state SYNC; shift registers and counters 0.
- Synchronisation and edge detection:
  - SCLK, LRCLK and DIN each pass through an identical 2-flop synchroniser, so their relative order is preserved.
  - sclk_rise = synchronised SCLK rising edge, detected as a single-Clk pulse.
  - lr_edge = synchronised LRCLK transition, evaluated on sclk_rise cycles only.
- State machine (advances only on sclk_rise):
  - SYNC: wait for an LRCLK 1→0 edge, so the first captured slot is always left. Then go to DELAY with skip = I2S_DELAY, or straight to SHIFT if I2S_DELAY = 0.
  - DELAY: ignore DIN for I2S_DELAY rises (the previous slot's last bit), then go to SHIFT.
  - SHIFT: shift DIN into the slot register MSB-first; bitcnt++. When bitcnt reaches DATA_W, close the slot and go to WAIT.
  - WAIT: ignore extra bits until lr_edge.
  - On lr_edge in SHIFT or WAIT:
    - Close the current slot (if not already closed) and start the next one: DELAY, or SHIFT when I2S_DELAY = 0.
    - A slot closed with bitcnt < DATA_W is left-aligned and zero-padded in its LSBs, and sets short_slot.
  - lr_edge and the DATA_W-th bit on the same rise: the bit is captured first, the slot is closed once, and short_slot is not set.
- Frame commit:
  - Closing a left slot stores it in a pending register.
  - Closing a right slot forms the frame {pending left, right}.
  - If out_valid = 0, or out_valid & out_ready in that same cycle, the frame loads left/right/left8/right8 and out_valid = 1 on the next Clk.
  - Otherwise the frame is dropped, the held data is unchanged, and overrun is set.
- Handshake:
  - out_valid stays high with stable data until out_ready.
  - The accepting cycle clears out_valid unless a new frame loads in that same cycle.
  - Latency: out_valid rises 1 Clk after the Clk on which the sclk_rise that closes the right slot is detected.
- 8-bit recovery per channel, s = sample:
  - t = s[DATA_W-1 -: 8].
  - If s < 0 and s[DATA_W-9:0] ≠ 0: out8 = t+1 (truncate toward zero); else out8 = t.
  - Examples: 0x7F7F7F→0x7F, 0xFEFEFF→0xFF, 0x808081→0x81, 0x800000→0x80, 0x000000→0x00.
- Sticky flags overrun and short_slot clear only on Reset.
- LRCLK stuck (no edges): the state machine parks in WAIT; no frames are produced and no flags are raised.
- Reset asserted mid-slot: the partial slot and the pending left sample are discarded; the block resynchronises from SYNC.

Decomposition:
- i2s_pkg holds:
  - default DATA_W;
  - state enum {SYNC, DELAY, SHIFT, WAIT};
  - function to_pcm8(sample) implementing the 8-bit rule above (shared with the transmit side for loopback checks).
- Sub-module i2s_sync: 2-flop synchroniser plus rising/any-edge pulse outputs; instantiated once per input pin.

Test Plan:
- Reset, then 3 standard I2S frames at Clk = 8× SCLK, L=0x7F7F7F, R=0x808081 → out_valid pulses ×3 (out_ready = 1); left = 0x7F7F7F, right = 0x808081, left8 = 0x7F, right8 = 0x81; flags 0.
- Stream starts mid right slot → first frame ignored until the LRCLK 1→0 edge; the first delivered frame is correctly aligned left/right.
- 32-bit slots with L=0x123456 followed by 8 junk bits → left = 0x123456 (junk ignored), short_slot = 0. Then 16-bit slots with L=0xABCD → left = 0xABCD00, short_slot = 1.
- Hold out_ready = 0 across 2 frames (F1 = 0x000001/0x000002, F2 = 0x000003/0x000004) → F1 held unchanged, overrun = 1. Then raise out_ready → F1 accepted, out_valid = 0 until F3.
- Full-scale negative L=0x800000, R=0xFEFEFF → left8 = 0x80, right8 = 0xFF. Loopback with the 8-bit transmitter sending 0x80, 0x01, 0xFF → identical 8-bit values recovered.
- Assert Reset for 1 Clk after 10 bits of the left slot → all outputs 0. The next full frame is received correctly with no flags set.
